// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single 64-bit data-memory port between two
// requesters (port 0 = load/store, port 1 = fetch/DMA). One grant at a time;
// the winner's command is registered and held until the memory completes.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration on simultaneous requests; without it port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [63:0]           p0_data_in,
  input  logic [7:0]            p0_bytemask,
  input  logic                  p0_write,
  output logic                  p0_done,
  output logic [63:0]           p0_data_out,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [63:0]           p1_data_in,
  input  logic [7:0]            p1_bytemask,
  input  logic                  p1_write,
  output logic                  p1_done,
  output logic [63:0]           p1_data_out,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [63:0]           mem_data_in,
  output logic [7:0]            mem_bytemask,
  output logic                  mem_write,
  output logic                  mem_start_access,
  input  logic                  mem_access_done,
  input  logic [63:0]           mem_data_out,
  output logic                  owner,
  output logic                  busy,
  output logic                  misalign_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  grant;
  logic                  grant_port;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [63:0]           sel_data_in;
  logic [7:0]            sel_bytemask;
  logic                  sel_write;
  logic                  in_busy;

  assign in_busy = (state == BUSY);

  // Next-state and arbitration: grants only from IDLE, so a completing
  // requester always gets one IDLE cycle to drop its request.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_port = owner;
    case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant      = 1'b1;
          state_next = BUSY;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          if (p0_req && p1_req) begin
            grant_port = ~owner;
          end else begin
            grant_port = p1_req;
          end
`else
          grant_port = ~p0_req;
`endif
        end
      end
      BUSY: begin
        if (mem_access_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Select the winning port's command fields for registration.
  always_comb begin
    sel_address  = p0_address;
    sel_data_in  = p0_data_in;
    sel_bytemask = p0_bytemask;
    sel_write    = p0_write;
    if (grant_port) begin
      sel_address  = p1_address;
      sel_data_in  = p1_data_in;
      sel_bytemask = p1_bytemask;
      sel_write    = p1_write;
    end
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command registers and owner, loaded only on the grant edge so the
  // memory sees a stable command for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= 1'b1;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_bytemask <= '0;
      mem_write    <= 1'b0;
    end else if (grant) begin
      owner        <= grant_port;
      mem_address  <= sel_address;
      mem_data_in  <= sel_data_in;
      mem_bytemask <= sel_bytemask;
      mem_write    <= sel_write;
    end
  end

  // Sticky misalignment flag, set when a granted address is not 8-byte aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (grant && (sel_address[2:0] != 3'b000)) begin
      misalign_err <= 1'b1;
    end
  end

  // Status and completion routing; done and read data pass straight through
  // to the owning port in the completion cycle.
  always_comb begin
    mem_start_access = in_busy;
    busy             = in_busy;
    p0_done          = in_busy && mem_access_done && (owner == 1'b0);
    p1_done          = in_busy && mem_access_done && (owner == 1'b1);
    p0_data_out      = '0;
    p1_data_out      = '0;
    if (in_busy && (owner == 1'b0)) begin
      p0_data_out = mem_data_out;
    end
    if (in_busy && (owner == 1'b1)) begin
      p1_data_out = mem_data_out;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter. The bench
// plays both requesters and the memory; expected values are hand-derived.
module tb_dmem_arbiter;

  localparam int ADDR_W = 20;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              p0_req, p1_req;
  logic [ADDR_W-1:0] p0_address, p1_address;
  logic [63:0]       p0_data_in, p1_data_in;
  logic [7:0]        p0_bytemask, p1_bytemask;
  logic              p0_write, p1_write;
  logic              p0_done, p1_done;
  logic [63:0]       p0_data_out, p1_data_out;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_data_in;
  logic [7:0]        mem_bytemask;
  logic              mem_write;
  logic              mem_start_access;
  logic              mem_access_done;
  logic [63:0]       mem_data_out;
  logic              owner;
  logic              busy;
  logic              misalign_err;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_WIDTH(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .p0_req           (p0_req),
    .p0_address       (p0_address),
    .p0_data_in       (p0_data_in),
    .p0_bytemask      (p0_bytemask),
    .p0_write         (p0_write),
    .p0_done          (p0_done),
    .p0_data_out      (p0_data_out),
    .p1_req           (p1_req),
    .p1_address       (p1_address),
    .p1_data_in       (p1_data_in),
    .p1_bytemask      (p1_bytemask),
    .p1_write         (p1_write),
    .p1_done          (p1_done),
    .p1_data_out      (p1_data_out),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_bytemask     (mem_bytemask),
    .mem_write        (mem_write),
    .mem_start_access (mem_start_access),
    .mem_access_done  (mem_access_done),
    .mem_data_out     (mem_data_out),
    .owner            (owner),
    .busy             (busy),
    .misalign_err     (misalign_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case a wait slips past its own bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic apply_stimulus(input bit port, input logic req,
                                input logic [ADDR_W-1:0] addr,
                                input logic [63:0] wdata,
                                input logic [7:0] mask, input logic wr);
    if (port == 1'b0) begin
      p0_req = req; p0_address = addr; p0_data_in = wdata;
      p0_bytemask = mask; p0_write = wr;
    end else begin
      p1_req = req; p1_address = addr; p1_data_in = wdata;
      p1_bytemask = mask; p1_write = wr;
    end
  endtask

  // Play the memory for one access: called at a negedge inside BUSY, raises
  // done on the lat-th BUSY cycle, checks the held command and the routing
  // of done/data, and returns just after the negedge of the following IDLE cycle.
  task automatic serve(input string tag, input bit exp_port, input int lat,
                       input logic [63:0] rdata, input logic [ADDR_W-1:0] exp_addr,
                       input logic exp_wr, input logic [7:0] exp_mask,
                       input logic [63:0] exp_wdata);
    int waited;
    waited = 0;
    while (busy !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_output({tag, ".busy"}, busy, 1);
    if (busy !== 1'b1) return;
    check_output({tag, ".owner"}, owner, exp_port);
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1) begin
        mem_access_done = 1'b1;
        mem_data_out    = rdata;
      end
      #1;
      check_output({tag, ".start"}, mem_start_access, 1);
      check_output({tag, ".addr"}, mem_address, exp_addr);
      check_output({tag, ".wr"}, mem_write, exp_wr);
      check_output({tag, ".mask"}, mem_bytemask, exp_mask);
      check_output({tag, ".wdata"}, mem_data_in, exp_wdata);
      if (i == lat - 1) begin
        check_output({tag, ".p0_done"}, p0_done, (exp_port == 1'b0));
        check_output({tag, ".p1_done"}, p1_done, (exp_port == 1'b1));
        check_output({tag, ".p0_rdata"}, p0_data_out, (exp_port == 1'b0) ? rdata : 64'h0);
        check_output({tag, ".p1_rdata"}, p1_data_out, (exp_port == 1'b1) ? rdata : 64'h0);
      end else begin
        check_output({tag, ".p0_early"}, p0_done, 0);
        check_output({tag, ".p1_early"}, p1_done, 0);
      end
      @(negedge clk);
    end
    mem_access_done = 1'b0;
    mem_data_out    = 64'h0;
    #1;
    check_output({tag, ".idle_start"}, mem_start_access, 0);
    check_output({tag, ".idle_busy"}, busy, 0);
    check_output({tag, ".idle_p0"}, p0_done, 0);
    check_output({tag, ".idle_p1"}, p1_done, 0);
  endtask

  // Directed sequence.
  initial begin
    reset = 1'b1;
    mem_access_done = 1'b0;
    mem_data_out = 64'h0;
    apply_stimulus(1'b0, 1'b0, '0, 64'h0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 64'h0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);

    // Reset state.
    check_output("rst.start", mem_start_access, 0);
    check_output("rst.busy", busy, 0);
    check_output("rst.owner", owner, 1);
    check_output("rst.addr", mem_address, 0);
    check_output("rst.wr", mem_write, 0);
    check_output("rst.misalign", misalign_err, 0);
    check_output("rst.p0_done", p0_done, 0);
    check_output("rst.p1_done", p1_done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single read from port 0, 3-cycle memory.
    apply_stimulus(1'b0, 1'b1, 20'h00040, 64'h0, 8'h00, 1'b0);
    @(negedge clk);
    serve("read", 1'b0, 3, 64'h1122334455667788, 20'h00040, 1'b0, 8'h00, 64'h0);
    p0_req = 1'b0;

    // Done from memory while IDLE must be ignored.
    @(negedge clk);
    mem_access_done = 1'b1;
    mem_data_out = 64'hDEADBEEF;
    #1;
    check_output("idle_done.p0", p0_done, 0);
    check_output("idle_done.p1", p1_done, 0);
    check_output("idle_done.busy", busy, 0);
    @(negedge clk);
    mem_access_done = 1'b0;
    mem_data_out = 64'h0;

    // Write forwarding from port 1.
    apply_stimulus(1'b1, 1'b1, 20'h00080, 64'hFFFF, 8'hFF, 1'b1);
    @(negedge clk);
    serve("write", 1'b1, 2, 64'h0, 20'h00080, 1'b1, 8'hFF, 64'hFFFF);
    p1_req = 1'b0;
    @(negedge clk);
    check_output("write.after_busy", busy, 0);

    // Late request: p1 rises while p0 is busy, granted right after the gap.
    apply_stimulus(1'b0, 1'b1, 20'h00100, 64'h0, 8'h00, 1'b0);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b1, 20'h00108, 64'h0, 8'h00, 1'b0);
    serve("late.p0", 1'b0, 3, 64'hCAFE0000CAFE0000, 20'h00100, 1'b0, 8'h00, 64'h0);
    p0_req = 1'b0;
    @(negedge clk);
    check_output("late.p1_granted", busy, 1);
    serve("late.p1", 1'b1, 2, 64'h0BADF00D0BADF00D, 20'h00108, 1'b0, 8'h00, 64'h0);
    p1_req = 1'b0;
    @(negedge clk);

    // Contention: both requesting continuously; last owner was port 1.
    apply_stimulus(1'b0, 1'b1, 20'h00200, 64'hA0A0, 8'h0F, 1'b1);
    apply_stimulus(1'b1, 1'b1, 20'h00300, 64'hB1B1, 8'hF0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit exp_port;
      exp_port = RR ? bit'(i % 2) : 1'b0;
      @(negedge clk);
      if (exp_port)
        serve("contend.p1", 1'b1, 2, 64'h1000 + 64'(i), 20'h00300, 1'b0, 8'hF0, 64'hB1B1);
      else
        serve("contend.p0", 1'b0, 2, 64'h1000 + 64'(i), 20'h00200, 1'b1, 8'h0F, 64'hA0A0);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    check_output("contend.drained", busy, 0);

    // Reset in the second BUSY cycle aborts the access.
    apply_stimulus(1'b0, 1'b1, 20'h00040, 64'h0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("abort.busy1", busy, 1);
    @(negedge clk);
    check_output("abort.busy2", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_output("abort.start", mem_start_access, 0);
    check_output("abort.busy", busy, 0);
    check_output("abort.p0_done", p0_done, 0);
    check_output("abort.owner", owner, 1);
    check_output("abort.addr", mem_address, 0);
    reset = 1'b0;
    @(negedge clk);
    serve("reread", 1'b0, 2, 64'h5555AAAA5555AAAA, 20'h00040, 1'b0, 8'h00, 64'h0);
    p0_req = 1'b0;
    @(negedge clk);

    // Misaligned grant proceeds and sets the sticky error.
    check_output("mis.before", misalign_err, 0);
    apply_stimulus(1'b0, 1'b1, 20'h00043, 64'h0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("mis.grant_edge", misalign_err, 1);
    serve("mis", 1'b0, 2, 64'h7777, 20'h00043, 1'b0, 8'h00, 64'h0);
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    check_output("mis.sticky", misalign_err, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("mis.cleared", misalign_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single 64-bit data-memory hierarchy (start_access/access_done handshake) between two requesters: port 0, the data/load-store side, and port 1, the instruction-fetch or DMA side. It grants one requester at a time and registers the winner's command. It drives that command to the memory, holding it stable until the memory completes, then returns completion and read data to the owner. It sits between the CPU-side request logic and the memory-hierarchy top module.

## Interface
- ADDR_WIDTH, 20, byte-address width; matches the memory's DMEM_ADDRESS_WIDTH.
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- pN_req  input  1  (N=0,1) request. Must be held with the command stable until pN_done.
- pN_address  input  ADDR_WIDTH  byte address; bits [2:0] must be 0.
- pN_data_in  input  64  write data.
- pN_bytemask  input  8  write byte enables.
- pN_write  input  1  1=write, 0=read.
- pN_done  output  1  access complete; high for exactly one cycle.
- pN_data_out  output  64  read data; valid only while pN_done=1.
- mem_address  output  ADDR_WIDTH  registered command to the memory.
- mem_data_in  output  64  registered command to the memory.
- mem_bytemask  output  8  registered command to the memory.
- mem_write  output  1  registered command to the memory.
- mem_start_access  output  1  registered; high only in BUSY.
- mem_access_done  input  1  memory completion.
- mem_data_out  input  64  memory read data.
- owner  output  1  port index of the current or last grant.
- busy  output  1  high in BUSY.
- misalign_err  output  1  sticky; set when a granted address has bits [2:0]≠0. Cleared only by reset.

## Operation
- The FSM has two states, IDLE and BUSY.
- IDLE:
  - If any pN_req=1, pick the winner. At the clock edge, latch the winner's address, data, bytemask and write into the mem_* registers, set owner, and go to BUSY.
  - If no request is pending, stay in IDLE.
- BUSY:
  - mem_start_access=1 and the mem_* outputs are constant.
  - pN_done = mem_access_done & (owner==N), combinational.
  - pN_data_out = mem_data_out when owner==N, else 0.
  - On the edge where mem_access_done=1, go to IDLE and deassert mem_start_access.
- Requests are never granted in the same cycle as completion. This one-cycle gap lets the finished requester drop its req first.
- A non-owner request stays pending while BUSY. It is granted in the next IDLE cycle.
- mem_access_done while in IDLE is ignored: pN_done stays 0.
- Misaligned grants still proceed. misalign_err is set on the grant edge.
- Reset values: state IDLE, mem_start_access 0, busy 0, owner 1 (so round-robin favours port 0 first), mem_* 0, misalign_err 0, pN_done 0.
- Reset mid-access aborts immediately. The same reset drives the memory, so no done is delivered for the aborted access.

## Timing
- Request present at edge T0 (IDLE) → mem_start_access=1 from T0 until the edge where mem_access_done=1.
- Latency seen by a requester = memory access latency + 1 cycle for arbitration.
- Read data and done are passed through combinationally in the completion cycle. No extra latency on return.
- Minimum spacing between successive grants: one IDLE cycle after each completion.
- Simultaneous requests in IDLE resolve by the arbitration policy (see Configuration).

## Configuration
- Macro DMEM_ARB_ROUND_ROBIN_EN:
  - Defined: on simultaneous requests, grant the port ≠ owner (strict alternation under continuous contention).
  - Undefined: fixed priority, port 0 always wins. Port 1 can starve under continuous port-0 traffic.
- All other behaviour is identical in both builds.

## Test plan
- Single read: p0_req, address 0x40, memory done after 3 cycles with data 0x1122334455667788:
  - mem_start_access high for 3 cycles.
  - p0_done for one cycle with p0_data_out=0x1122334455667788.
  - p1_done stays 0.
- Write forwarding: p1 write to 0x80, data 0xFFFF, bytemask 0xFF:
  - mem_address=0x80, mem_write=1, mem_bytemask=0xFF, all stable until done.
  - Then IDLE and busy=0.
- Contention with DMEM_ARB_ROUND_ROBIN_EN, both ports requesting continuously from reset, each request re-raised after its done:
  - Grant order 0,1,0,1.
  - Without the macro: grant order 0,0,0; p1 is not granted while p0_req stays high.
- Late request: p1_req rises while p0 is BUSY → p1 is granted on the edge after p0 completes, with no done pulse to p1 before that.
- Reset mid-access: reset asserted in the second BUSY cycle → next cycle mem_start_access=0, busy=0, no pN_done. A subsequent p0 read completes normally.
- Misalignment: p0 grant at address 0x43 → misalign_err=1 from the grant edge. It remains 1 after completion until reset.
